rpsc_fault_annunciator: RTL and testbench

//  Control-room side of the RPSC fault-card lamp interface. Takes the eight FFx_LA latch-alarm lines
//  and the emergency line from the card and runs a per-channel annunciator sequence (fast flash

---
 rtl/rpsc_fault_annunciator.sv | 248 ++++++++++++++++++++++++
 tb/tb_rpsc_fault_annunciator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rpsc_fault_annunciator.sv
// rpsc_fault_annunciator
// Control-room annunciator for the RPSC fault card. Conditions the raw card
// lines and operator pushbuttons, runs one alarm sequence per channel
// (fast flash unacknowledged / steady acknowledged / slow flash ringback) and
// drives the panel lamps, the horn, the emergency lamp and the first-out
// register. All outputs are registered.

module rpsc_fault_annunciator #(
    parameter int N_CH      = 8,
    parameter int DEB_CYC   = 50000,
    parameter int FAST_HALF = 6250000,
    parameter int SLOW_HALF = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         i_fault_la,
    input  logic                    i_emergency,
    input  logic                    i_ack,
    input  logic                    i_rst_btn,
    input  logic                    i_lamptest,
    output logic [N_CH-1:0]         o_lamp,
    output logic                    o_horn,
    output logic                    o_emerg_lamp,
    output logic [$clog2(N_CH)-1:0] o_first_out,
    output logic                    o_first_vld
);

    localparam int IDX_W  = $clog2(N_CH);
    localparam int N_IN   = N_CH + 4;
    localparam int DEB_W  = $clog2(DEB_CYC + 1);
    localparam int FAST_W = $clog2(FAST_HALF + 1);
    localparam int SLOW_W = $clog2(SLOW_HALF + 1);

    // Bit positions of the operator/emergency lines inside the conditioned bus.
    localparam int B_EMERG = N_CH;
    localparam int B_ACK   = N_CH + 1;
    localparam int B_RST   = N_CH + 2;
    localparam int B_LT    = N_CH + 3;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        UNACK    = 2'd1,
        ACKED    = 2'd2,
        RINGBACK = 2'd3
    } ch_state_e;

    // ------------------------------------------------------------------
    // Input conditioning state
    // ------------------------------------------------------------------
    logic [N_IN-1:0]             raw_in;
    logic [N_IN-1:0]             sync1_q, sync1_d;
    logic [N_IN-1:0]             sync2_q, sync2_d;
    logic [N_IN-1:0]             filt_q, filt_d;
    logic [N_IN-1:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic                        ack_prev_q, ack_prev_d;
    logic                        rst_prev_q, rst_prev_d;

    logic [N_CH-1:0] fault_f;
    logic            emerg_f, ack_f, rst_f, lamptest_f;
    logic            ack_edge, rst_edge;

    // Flash generator state
    logic [FAST_W-1:0] fast_cnt_q, fast_cnt_d;
    logic [SLOW_W-1:0] slow_cnt_q, slow_cnt_d;
    logic              fast_ph_q, fast_ph_d;
    logic              slow_ph_q, slow_ph_d;

    // Channel FSM state
    ch_state_e state_q [N_CH];
    ch_state_e state_d [N_CH];
    logic      all_normal;
    logic      all_normal_prev_q, all_normal_prev_d;

    // Output registers
    logic [N_CH-1:0]  lamp_q, lamp_d;
    logic             horn_q, horn_d;
    logic             emerg_lamp_q, emerg_lamp_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic             first_vld_q, first_vld_d;

    assign raw_in     = {i_lamptest, i_rst_btn, i_ack, i_emergency, i_fault_la};
    assign fault_f    = filt_q[N_CH-1:0];
    assign emerg_f    = filt_q[B_EMERG];
    assign ack_f      = filt_q[B_ACK];
    assign rst_f      = filt_q[B_RST];
    assign lamptest_f = filt_q[B_LT];
    assign ack_edge   = ack_f & ~ack_prev_q;
    assign rst_edge   = rst_f & ~rst_prev_q;

    // Synchronize, then accept a new level only after DEB_CYC stable cycles.
    always_comb begin
        sync1_d    = raw_in;
        sync2_d    = sync1_q;
        ack_prev_d = ack_f;
        rst_prev_d = rst_f;
        // NOTE: every comb output gets a default before any branch, so no latch is inferred.
        filt_d     = filt_q;
        deb_cnt_d  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CYC - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Free-running flash counters shared by all channels.
    always_comb begin
        fast_cnt_d = fast_cnt_q + 1'b1;
        fast_ph_d  = fast_ph_q;
        if (fast_cnt_q == FAST_W'(FAST_HALF - 1)) begin
            fast_cnt_d = '0;
            fast_ph_d  = ~fast_ph_q;
        end
        slow_cnt_d = slow_cnt_q + 1'b1;
        slow_ph_d  = slow_ph_q;
        if (slow_cnt_q == SLOW_W'(SLOW_HALF - 1)) begin
            slow_cnt_d = '0;
            slow_ph_d  = ~slow_ph_q;
        end
    end

    // Input conditioning and flash registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            deb_cnt_q  <= '0;
            ack_prev_q <= 1'b0;
            rst_prev_q <= 1'b0;
            fast_cnt_q <= '0;
            slow_cnt_q <= '0;
            fast_ph_q  <= 1'b1;
            slow_ph_q  <= 1'b1;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values.
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            deb_cnt_q  <= deb_cnt_d;
            ack_prev_q <= ack_prev_d;
            rst_prev_q <= rst_prev_d;
            fast_cnt_q <= fast_cnt_d;
            slow_cnt_q <= slow_cnt_d;
            fast_ph_q  <= fast_ph_d;
            slow_ph_q  <= slow_ph_d;
        end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= NORMAL;
            end
            all_normal_prev_q <= 1'b1;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
            end
            all_normal_prev_q <= all_normal_prev_d;
        end
    end

    // Channel next-state: ACK acts on UNACK, RESET on RINGBACK, one step per cycle.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                NORMAL:   if (fault_f[i]) state_d[i] = UNACK;
                UNACK:    if (ack_edge) state_d[i] = fault_f[i] ? ACKED : NORMAL;
                ACKED:    if (!fault_f[i]) state_d[i] = RINGBACK;
                RINGBACK: begin
                    // A returning fault outranks a same-cycle RESET.
                    if (fault_f[i])    state_d[i] = UNACK;
                    else if (rst_edge) state_d[i] = NORMAL;
                end
                default:  state_d[i] = NORMAL;
            endcase
        end
    end

    // Output decode: lamps, horn, emergency lamp and first-out tracking.
    always_comb begin
        lamp_d       = '0;
        horn_d       = emerg_f;
        all_normal   = 1'b1;
        first_idx_d  = first_idx_q;
        first_vld_d  = first_vld_q;
        for (int i = 0; i < N_CH; i++) begin
            unique case (state_q[i])
                NORMAL:   lamp_d[i] = 1'b0;
                UNACK:    lamp_d[i] = fast_ph_q;
                ACKED:    lamp_d[i] = 1'b1;
                RINGBACK: lamp_d[i] = slow_ph_q;
                default:  lamp_d[i] = 1'b0;
            endcase
            if (state_q[i] == UNACK)  horn_d     = 1'b1;
            if (state_q[i] != NORMAL) all_normal = 1'b0;
        end
        if (lamptest_f) lamp_d = '1;
        emerg_lamp_d      = emerg_f | lamptest_f;
        all_normal_prev_d = all_normal;

        if (first_vld_q) begin
            if (all_normal) begin
                first_vld_d = 1'b0;
                first_idx_d = '0;
            end
        end else if (all_normal_prev_q && !all_normal) begin
            // Leaving all-NORMAL can only mean entering UNACK; lowest index wins.
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (state_q[i] == UNACK) begin
                    first_idx_d = IDX_W'(i);
                    first_vld_d = 1'b1;
                end
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lamp_q       <= '0;
            horn_q       <= 1'b0;
            emerg_lamp_q <= 1'b0;
            first_idx_q  <= '0;
            first_vld_q  <= 1'b0;
        end else begin
            lamp_q       <= lamp_d;
            horn_q       <= horn_d;
            emerg_lamp_q <= emerg_lamp_d;
            first_idx_q  <= first_idx_d;
            first_vld_q  <= first_vld_d;
        end
    end

    assign o_lamp       = lamp_q;
    assign o_horn       = horn_q;
    assign o_emerg_lamp = emerg_lamp_q;
    assign o_first_out  = first_idx_q;
    assign o_first_vld  = first_vld_q;

endmodule

// File: tb/tb_rpsc_fault_annunciator.sv
// Testbench for rpsc_fault_annunciator with short debounce and flash periods.
// Expected output snapshots are queued when stimulus is applied and compared
// once the conditioning/FSM/output latency has elapsed.

module tb_rpsc_fault_annunciator;

    localparam int N_CH      = 8;
    localparam int DEB_CYC   = 4;
    localparam int FAST_HALF = 4;
    localparam int SLOW_HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] i_fault_la;
    logic       i_emergency, i_ack, i_rst_btn, i_lamptest;
    logic [7:0] o_lamp;
    logic       o_horn, o_emerg_lamp, o_first_vld;
    logic [2:0] o_first_out;

    rpsc_fault_annunciator #(
        .N_CH(N_CH), .DEB_CYC(DEB_CYC), .FAST_HALF(FAST_HALF), .SLOW_HALF(SLOW_HALF)
    ) dut (
        .clk(clk), .reset(reset), .i_fault_la(i_fault_la), .i_emergency(i_emergency),
        .i_ack(i_ack), .i_rst_btn(i_rst_btn), .i_lamptest(i_lamptest),
        .o_lamp(o_lamp), .o_horn(o_horn), .o_emerg_lamp(o_emerg_lamp),
        .o_first_out(o_first_out), .o_first_vld(o_first_vld)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset release; the flash model is built on it.
    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        string      tag;
        logic [7:0] lamp;
        logic       horn;
        logic       emerg;
        logic [2:0] fo;
        logic       fv;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Phase after k counted edges: starts at 1 and toggles every half period.
    function automatic logic fast_ph(input int k);
        return ((k / FAST_HALF) % 2) == 0;
    endfunction

    function automatic logic slow_ph(input int k);
        return ((k / SLOW_HALF) % 2) == 0;
    endfunction

    task automatic push_exp(input string tag, input logic [7:0] lamp, input logic horn,
                            input logic emerg, input logic [2:0] fo, input logic fv);
        exp_t e;
        e.tag = tag; e.lamp = lamp; e.horn = horn; e.emerg = emerg; e.fo = fo; e.fv = fv;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, ".lamp"},  32'(o_lamp),       32'(e.lamp));
        check({e.tag, ".horn"},  32'(o_horn),       32'(e.horn));
        check({e.tag, ".emerg"}, 32'(o_emerg_lamp), 32'(e.emerg));
        check({e.tag, ".fo"},    32'(o_first_out),  32'(e.fo));
        check({e.tag, ".fv"},    32'(o_first_vld),  32'(e.fv));
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Lamp vector for channels flashing fast, sampled after n more edges.
    function automatic logic [7:0] fast_lamp(input logic [7:0] mask, input int n);
        return fast_ph(cyc + n - 1) ? mask : 8'h00;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; i_fault_la = '0; i_emergency = 0; i_ack = 0; i_rst_btn = 0; i_lamptest = 0;
        tick(3);
        push_exp("reset", 8'h00, 0, 0, 3'd0, 0);
        compare_out();
        reset = 1'b1;
        tick(2);

        // 1: a 3-cycle glitch is shorter than the debounce window.
        i_fault_la[2] = 1'b1;
        tick(3);
        i_fault_la[2] = 1'b0;
        push_exp("t1_glitch", 8'h00, 0, 0, 3'd0, 0);
        tick(12);
        compare_out();

        // 2: held fault on ch5; nothing visible until 2+DEB+1 cycles plus output reg.
        i_fault_la[5] = 1'b1;
        push_exp("t2_pre", 8'h00, 0, 0, 3'd0, 0);
        tick(7);
        compare_out();
        push_exp("t2_alarm", fast_lamp(8'h20, 1), 1, 0, 3'd5, 1);
        tick(1);
        compare_out();
        for (int i = 0; i < 4; i++) begin
            push_exp("t2_flash", fast_lamp(8'h20, 2), 1, 0, 3'd5, 1);
            tick(2);
            compare_out();
        end
        i_ack = 1'b1;
        push_exp("t2_ack", 8'h20, 0, 0, 3'd5, 1);
        tick(8);
        compare_out();
        i_ack = 1'b0;
        push_exp("t2_steady", 8'h20, 0, 0, 3'd5, 1);
        tick(10);
        compare_out();

        // 3: fault clears -> ringback slow flash, then RESET returns to normal.
        i_fault_la[5] = 1'b0;
        push_exp("t3_ring", slow_ph(cyc + 7) ? 8'h20 : 8'h00, 0, 0, 3'd5, 1);
        tick(8);
        compare_out();
        for (int i = 0; i < 4; i++) begin
            push_exp("t3_slow", slow_ph(cyc + 3) ? 8'h20 : 8'h00, 0, 0, 3'd5, 1);
            tick(4);
            compare_out();
        end
        i_rst_btn = 1'b1;
        push_exp("t3_reset", 8'h00, 0, 0, 3'd0, 0);
        tick(8);
        compare_out();
        i_rst_btn = 1'b0;
        tick(10);

        // 4: two channels in one cycle -> lowest index is first-out; lock-in of ch1.
        i_fault_la = 8'b0100_0010;
        push_exp("t4_two", fast_lamp(8'h42, 8), 1, 0, 3'd1, 1);
        tick(8);
        compare_out();
        i_fault_la[1] = 1'b0;
        push_exp("t4_lockin", fast_lamp(8'h42, 10), 1, 0, 3'd1, 1);
        tick(10);
        compare_out();
        i_ack = 1'b1;
        push_exp("t4_ack", 8'h40, 0, 0, 3'd1, 1);
        tick(8);
        compare_out();
        i_ack = 1'b0;
        tick(10);
        i_fault_la[6] = 1'b0;
        tick(10);
        i_rst_btn = 1'b1;
        tick(10);
        i_rst_btn = 1'b0;
        push_exp("t4_clear", 8'h00, 0, 0, 3'd0, 0);
        tick(10);
        compare_out();

        // 5: ch3 to RINGBACK, then fault returns on the same cycle as the RESET edge.
        i_fault_la[3] = 1'b1;
        tick(10);
        i_ack = 1'b1;
        tick(10);
        i_ack = 1'b0;
        push_exp("t5_acked", 8'h08, 0, 0, 3'd3, 1);
        tick(10);
        compare_out();
        i_fault_la[3] = 1'b0;
        tick(10);
        i_fault_la[3] = 1'b1;
        i_rst_btn     = 1'b1;
        push_exp("t5_fault_wins", fast_lamp(8'h08, 8), 1, 0, 3'd3, 1);
        tick(8);
        compare_out();
        i_rst_btn  = 1'b0;
        i_lamptest = 1'b1;
        push_exp("t5_lamptest", 8'hFF, 1, 1, 3'd3, 1);
        tick(8);
        compare_out();
        i_lamptest = 1'b0;
        push_exp("t5_lt_off", fast_lamp(8'h08, 10), 1, 0, 3'd3, 1);
        tick(10);
        compare_out();

        // 6: async reset mid-alarm with emergency active, then re-alarm.
        i_emergency = 1'b1;
        tick(10);
        reset = 1'b0;
        #1;
        push_exp("t6_async_rst", 8'h00, 0, 0, 3'd0, 0);
        compare_out();
        tick(3);
        reset = 1'b1;
        push_exp("t6_pre", 8'h00, 0, 0, 3'd0, 0);
        tick(6);
        compare_out();
        push_exp("t6_realarm", fast_lamp(8'h08, 2), 1, 1, 3'd3, 1);
        tick(2);
        compare_out();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
